// File: rtl/dmem_arbiter.sv
// Two-port arbiter and sequencer in front of the single-port datamemory: one memory access
// per 3-cycle transaction (IDLE -> ACCESS -> RESP). Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              owner,
  output logic [CNT_W-1:0]  txn_count,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, stateNext;
  logic   lastGrant;
  logic   memWeQ;
  logic   accept;
  logic   winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    stateNext = state;
    accept    = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    busy      = 1'b0;
    mem_we    = 1'b0;
    // A lone request always wins; lastGrant only matters on a tie with round-robin enabled.
    if (req0 && req1) winner = RrEn && !lastGrant;
    else              winner = req1;

    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept    = 1'b1;
          stateNext = ACCESS;
        end
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_we    = memWeQ;
        stateNext = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        ack0      = !owner;
        ack1      = owner;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // mem_we is decoded from state, so an async reset in ACCESS kills the write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      owner     <= 1'b0;
      lastGrant <= 1'b1;
      memWeQ    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      rdata     <= '0;
      txn_count <= '0;
    end else begin
      if (accept) begin
        owner     <= winner;
        lastGrant <= winner;
        memWeQ    <= winner ? we1    : we0;
        mem_addr  <= winner ? addr1  : addr0;
        mem_din   <= winner ? wdata1 : wdata0;
      end
      if (state == ACCESS) rdata <= mem_dout;
      // Counts on the RESP exit edge; natural wrap from all-ones to zero.
      txn_count <= txn_count + CNT_W'(state == RESP);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural 16-word datamemory model.
// Expectations follow the build: DMEM_ARB_ROUND_ROBIN_EN selects the round-robin grant order.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, busy, owner, memWe;
  logic [31:0] rdata, memAddr, memDin, memDout;
  logic [15:0] txnCount;

  int checks   = 0;
  int failures = 0;

  logic [31:0] memArr [16] = '{default: 32'h0};

  typedef struct {
    logic        accWe, accOwner, accBusy, accAck0, accAck1;
    logic        rspWe, rspAck0, rspAck1, rspOwner;
    logic [31:0] rspData;
    logic        idlAck0, idlAck1, idlBusy;
  } obs_t;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst_n(rstN),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .owner(owner),
    .txn_count(txnCount), .mem_we(memWe), .mem_addr(memAddr), .mem_din(memDin),
    .mem_dout(memDout)
  );

  // datamemory: combinational read, synchronous write
  assign memDout = memArr[4'(memAddr % 32'd16)];
  always @(posedge clk) if (memWe) memArr[4'(memAddr % 32'd16)] <= memDin;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic clear_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rstN = 0;
    repeat (2) @(negedge clk);
    rstN = 1;
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns one negedge after the transaction ends.
  task automatic run_txn(input bit port, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input bit perturb, output obs_t o);
    if (port) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    else      begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    @(negedge clk);
    o.accWe = memWe; o.accOwner = owner; o.accBusy = busy; o.accAck0 = ack0; o.accAck1 = ack1;
    if (perturb) begin
      if (port) begin addr1 = 32'd7; wdata1 = 32'hF; end
      else      begin addr0 = 32'd7; wdata0 = 32'hF; end
    end
    @(negedge clk);
    o.rspWe = memWe; o.rspAck0 = ack0; o.rspAck1 = ack1; o.rspOwner = owner; o.rspData = rdata;
    req0 = 0; req1 = 0;
    @(negedge clk);
    o.idlAck0 = ack0; o.idlAck1 = ack1; o.idlBusy = busy;
  endtask

  task automatic test_reset();
    clear_inputs();
    rstN = 0;
    #3;
    checks++;
    if ({ack0, ack1, memWe, busy, owner} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000", {ack0, ack1, memWe, busy, owner});
    end
    checks++;
    if ({memAddr, memDin, rdata} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data got addr=%h din=%h rdata=%h exp=0", memAddr, memDin, rdata);
    end
    checks++;
    if (txnCount !== 16'h0) begin
      failures++;
      $display("FAIL reset_count got=%h exp=0000", txnCount);
    end
    @(negedge clk);
    rstN = 1;
    @(negedge clk);
  endtask

  task automatic test_port0_write_read();
    obs_t o;
    run_txn(1'b0, 1'b1, 32'd3, 32'hA, 1'b0, o);
    checks++;
    if ({o.accWe, o.rspWe, o.accBusy, o.accOwner} !== 4'b1010) begin
      failures++;
      $display("FAIL p0_write_we got we1/we2/busy/owner=%b exp=1010",
               {o.accWe, o.rspWe, o.accBusy, o.accOwner});
    end
    checks++;
    if ({o.accAck0, o.rspAck0, o.rspAck1, o.idlAck0, o.idlBusy} !== 5'b01000) begin
      failures++;
      $display("FAIL p0_write_ack got=%b exp=01000",
               {o.accAck0, o.rspAck0, o.rspAck1, o.idlAck0, o.idlBusy});
    end
    checks++;
    if (memArr[3] !== 32'hA) begin
      failures++;
      $display("FAIL p0_write_mem got=%h exp=0000000a", memArr[3]);
    end
    run_txn(1'b0, 1'b0, 32'd3, 32'h0, 1'b0, o);
    checks++;
    if (o.accWe !== 1'b0 || o.rspAck0 !== 1'b1 || o.rspData !== 32'hA) begin
      failures++;
      $display("FAIL p0_read got we=%b ack0=%b rdata=%h exp we=0 ack0=1 rdata=0000000a",
               o.accWe, o.rspAck0, o.rspData);
    end
    checks++;
    if (txnCount !== 16'd2) begin
      failures++;
      $display("FAIL p0_count got=%0d exp=2", txnCount);
    end
  endtask

  task automatic test_port1_alone();
    obs_t o1, o2;
    run_txn(1'b1, 1'b1, 32'd1, 32'hC, 1'b0, o1);
    run_txn(1'b1, 1'b0, 32'd1, 32'h0, 1'b0, o2);
    checks++;
    if ({o1.accOwner, o1.rspOwner, o2.accOwner, o2.rspOwner} !== 4'b1111) begin
      failures++;
      $display("FAIL p1_owner got=%b exp=1111", {o1.accOwner, o1.rspOwner, o2.accOwner, o2.rspOwner});
    end
    checks++;
    if ({o1.rspAck1, o2.rspAck1, o1.rspAck0, o2.rspAck0, o1.accAck0, o2.accAck0} !== 6'b110000) begin
      failures++;
      $display("FAIL p1_acks got=%b exp=110000",
               {o1.rspAck1, o2.rspAck1, o1.rspAck0, o2.rspAck0, o1.accAck0, o2.accAck0});
    end
    checks++;
    if (o2.rspData !== 32'hC) begin
      failures++;
      $display("FAIL p1_rdata got=%h exp=0000000c", o2.rspData);
    end
    checks++;
    if (txnCount !== 16'd4) begin
      failures++;
      $display("FAIL p1_count got=%0d exp=4", txnCount);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] grants;
    logic [3:0] expGrants;
    int         nGrant = 0;
    int         nAck   = 0;
    bit         sawAck1 = 0;
    bit         dataBad = 0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    expGrants = 4'b1010;  // grant[i] at bit i: 0,1,0,1
`else
    expGrants = 4'b0000;
`endif
    grants = 4'b0;
    apply_reset();
    req0 = 1; we0 = 0; addr0 = 32'd3;
    req1 = 1; we1 = 0; addr1 = 32'd1;
    for (int cyc = 0; cyc < 20 && nAck < 4; cyc++) begin
      @(negedge clk);
      if (busy && !ack0 && !ack1 && nGrant < 4) begin
        grants[nGrant] = owner;
        nGrant++;
      end
      if (ack1) sawAck1 = 1;
      if (ack0 && rdata !== 32'hA) dataBad = 1;
      if (ack1 && rdata !== 32'hC) dataBad = 1;
      if (ack0 || ack1) begin
        nAck++;
        if (nAck == 4) begin req0 = 0; req1 = 0; end
      end
    end
    req0 = 0; req1 = 0;
    @(negedge clk);
    checks++;
    if (nAck != 4 || nGrant != 4) begin
      failures++;
      $display("FAIL sim_progress got acks=%0d grants=%0d exp 4/4 within 20 cycles", nAck, nGrant);
    end
    checks++;
    if (grants !== expGrants) begin
      failures++;
      $display("FAIL sim_order got=%b exp=%b (bit i = grant i)", grants, expGrants);
    end
    checks++;
    if (sawAck1 !== expGrants[1]) begin
      failures++;
      $display("FAIL sim_ack1 got=%b exp=%b", sawAck1, expGrants[1]);
    end
    checks++;
    if (dataBad) begin
      failures++;
      $display("FAIL sim_rdata got=bad exp=a for port0 c for port1");
    end
  endtask

  task automatic test_input_change();
    obs_t o;
    run_txn(1'b0, 1'b1, 32'd3, 32'h0, 1'b0, o);
    run_txn(1'b0, 1'b1, 32'd3, 32'hA, 1'b1, o);
    checks++;
    if (memArr[3] !== 32'hA || memArr[7] !== 32'h0) begin
      failures++;
      $display("FAIL chg_mem got m3=%h m7=%h exp m3=0000000a m7=00000000", memArr[3], memArr[7]);
    end
    checks++;
    if (memAddr !== 32'd3 || memDin !== 32'hA || o.rspAck0 !== 1'b1) begin
      failures++;
      $display("FAIL chg_latch got addr=%h din=%h ack0=%b exp 3/a/1", memAddr, memDin, o.rspAck0);
    end
  endtask

  task automatic test_reset_mid_op();
    req0 = 1; we0 = 1; addr0 = 32'd2; wdata0 = 32'h5;
    @(negedge clk);
    checks++;
    if (memWe !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_we got=%b exp=1", memWe);
    end
    #2 rstN = 0;
    #1;
    checks++;
    if (memWe !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_drop got we=%b busy=%b exp 0/0", memWe, busy);
    end
    @(negedge clk);
    checks++;
    if ({ack0, ack1} !== 2'b00 || txnCount !== 16'h0 || memArr[2] !== 32'h0) begin
      failures++;
      $display("FAIL rst_after got acks=%b count=%h m2=%h exp 00/0000/00000000",
               {ack0, ack1}, txnCount, memArr[2]);
    end
    clear_inputs();
    rstN = 1;
    @(negedge clk);
  endtask

  task automatic test_counter_wrap();
    obs_t o;
    force dut.txn_count = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.txn_count;
    @(negedge clk);
    checks++;
    if (txnCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_preload got=%h exp=ffff", txnCount);
    end
    run_txn(1'b0, 1'b0, 32'd3, 32'h0, 1'b0, o);
    checks++;
    if (txnCount !== 16'h0000 || o.rspData !== 32'hA) begin
      failures++;
      $display("FAIL wrap_count got count=%h rdata=%h exp 0000/0000000a", txnCount, o.rspData);
    end
  endtask

  initial begin
    test_reset();
    test_port0_write_read();
    test_port1_alone();
    test_simultaneous();
    test_input_change();
    test_reset_mid_op();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port `datamemory` block (sync write on `clk`, `DataOut` combinational from `Addr`).
- Port 0 is the CPU load/store path. Port 1 is the loader/debug path.
- Serialises requests into single memory accesses, drives `regWE`/`Addr`/`DataIn`, and returns registered read data with a one-cycle ack.

Parameters:
- `ADDR_W`, 32, address width passed to `datamemory`.
- `DATA_W`, 32, data width.
- `CNT_W`, 16, width of the completed-transaction counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req0`, `req1`  in  1  request from port 0 / port 1.
- `we0`, `we1`  in  1  1 = write, 0 = read.
- `addr0`, `addr1`  in  `ADDR_W`  request address.
- `wdata0`, `wdata1`  in  `DATA_W`  write data.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  `DATA_W`  read data; valid while an ack is high.
- `busy`  out  1  high in ACCESS or RESP.
- `owner`  out  1  port currently being served.
- `txn_count`  out  `CNT_W`  number of completed transactions.
- `mem_we`  out  1  to `datamemory` `regWE`.
- `mem_addr`  out  `ADDR_W`  to `datamemory` `Addr`.
- `mem_din`  out  `DATA_W`  to `datamemory` `DataIn`.
- `mem_dout`  in  `DATA_W`  from `datamemory` `DataOut`.

Behaviour:
- Reset (async, `rst_n`=0) forces:
  - state = IDLE;
  - `ack0`/`ack1`/`mem_we`/`busy`/`owner` = 0;
  - `mem_addr`/`mem_din`/`rdata`/`txn_count` = 0;
  - `last_grant` = 1.
- FSM states are IDLE, ACCESS and RESP. Each transaction takes exactly 3 cycles. A new transaction can start at the earliest 3 cycles after the previous one.
- IDLE:
  - If any request is high at the clock edge, select a winner.
  - Latch the winner's `we`/`addr`/`wdata` into `mem_we_q`/`mem_addr`/`mem_din`.
  - Set `owner` = winner and `last_grant` = winner, then go to ACCESS.
  - If no request is high, stay in IDLE.
- ACCESS:
  - `mem_we` = latched `we`. `mem_we` is high only in this state and is gated combinationally by state.
  - The memory write occurs at the edge leaving ACCESS.
  - `rdata` <= `mem_dout` on that edge; it is captured for writes too.
  - Go to RESP.
- RESP:
  - `ack[owner]` = 1 for this cycle only; the other ack stays 0.
  - `txn_count` increments at the edge leaving RESP and wraps to 0 from all-ones.
  - Go to IDLE.
- Requester contract:
  - Hold `req`/`we`/`addr`/`wdata` stable from assertion until `ack`.
  - Requests are sampled only in IDLE; input changes during ACCESS/RESP are ignored.
  - A `req` still high in IDLE after `ack` is treated as a new transaction.
- Arbitration on simultaneous requests in IDLE follows the Optional Feature. A single active request always wins.
- `mem_addr`/`mem_din` hold their last latched value between transactions.
- `rdata` holds its value until the next ACCESS exit.
- Reset mid-transaction:
  - `mem_we` drops immediately, so no write occurs if reset is asserted before the ACCESS edge.
  - No ack is issued and `txn_count` is not incremented.

Optional Feature:
- Macro `DMEM_ARB_ROUND_ROBIN_EN`.
- Defined: on simultaneous `req0` and `req1` in IDLE, the winner is `!last_grant`. Because `last_grant` resets to 1, port 0 wins the first tie.
- Undefined: fixed priority, port 0 always wins ties. `last_grant` is still updated but does not affect selection. Port 1 can starve; this is accepted.

Test Plan:
- Write then read, port 0:
  - `req0`=1, `we0`=1, `addr0`=3, `wdata0`=0xA -> `mem_we`=1 only in cycle 1, `ack0` in cycle 2.
  - Then `we0`=0, `addr0`=3 -> `ack0` with `rdata`=0xA.
  - `txn_count`=2.
- Port 1 alone: write `addr1`=1 with 0xC, then read `addr1`=1 -> `ack1` pulses, `rdata`=0xC, `owner`=1 during `busy`, `ack0` never pulses.
- Simultaneous requests held 4 transactions:
  - With `DMEM_ARB_ROUND_ROBIN_EN`: grant order 0,1,0,1.
  - Without it: 0,0,0,0, and `ack1` never pulses.
- Input change during ACCESS: after acceptance, set `addr0`=7 and `wdata0`=0xF in cycle 1 -> memory written at the latched `addr`=3 with 0xA; `addr` 7 unchanged.
- Reset mid-op: assert `rst_n`=0 during ACCESS of a write of 0x5 to `addr` 2 -> `mem_we` falls immediately, no ack, `txn_count`=0, `addr` 2 keeps its old value.
- Counter wrap: preload (force) `txn_count`=0xFFFF, complete one read -> `txn_count`=0x0000.
